// File: rtl/latch_ff_seq_pkg.sv
// Shared types and helpers for the master/slave latch sequencer.
package latch_ff_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_MOPEN = 3'd2,
      ST_GAP1  = 3'd3,
      ST_SOPEN = 3'd4,
      ST_GAP2  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   localparam int MIN_CYC = 1;

   // Cycles from the accept edge through the end of DONE.
   function automatic int seq_len(input int setup_cyc, input int pulse_cyc, input int gap_cyc);
      return setup_cyc + 2 * pulse_cyc + 2 * gap_cyc + 1;
   endfunction

   function automatic int clamp_cyc(input int cyc);
      return (cyc < MIN_CYC) ? MIN_CYC : cyc;
   endfunction

endpackage

// File: rtl/latch_ff_seq_timer.sv
// Loadable down-counter that times every phase of the latch sequence.
module phase_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   output logic          o_zero
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/latch_ff_seq.sv
// Sequences non-overlapping master/slave latch enables for one data bit per
// handshake, then checks the slave readback against the captured bit.
//
// state | meaning
// IDLE  | ready for a request
// SETUP | latch_d settling before the master opens
// MOPEN | master latch enable high
// GAP1  | both enables low between master and slave pulses
// SOPEN | slave latch enable high
// GAP2  | both enables low before completion
// DONE  | ack for one cycle, err holds the readback compare
module latch_ff_seq
   import latch_ff_seq_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1,
   parameter int CW        = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic din,
   output logic ready,
   output logic latch_d,
   output logic en_m,
   output logic en_s,
   input  logic q_in,
   output logic ack,
   output logic err
);

   localparam logic [CW-1:0] LD_SETUP = CW'(clamp_cyc(SETUP_CYC) - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(clamp_cyc(PULSE_CYC) - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(clamp_cyc(GAP_CYC) - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_zero;
   logic          w_accept;

   logic r_ready;
   logic r_latch_d;
   logic r_en_m;
   logic r_en_s;
   logic r_ack;
   logic r_err;

   phase_timer #(.CW(CW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE:  w_accept = req && r_ready;
         ST_SETUP: if (w_zero) begin
            w_state_nxt = ST_MOPEN;
            w_load      = 1'b1;
            w_load_val  = LD_PULSE;
         end
         ST_MOPEN: if (w_zero) begin
            w_state_nxt = ST_GAP1;
            w_load      = 1'b1;
            w_load_val  = LD_GAP;
         end
         ST_GAP1:  if (w_zero) begin
            w_state_nxt = ST_SOPEN;
            w_load      = 1'b1;
            w_load_val  = LD_PULSE;
         end
         ST_SOPEN: if (w_zero) begin
            w_state_nxt = ST_GAP2;
            w_load      = 1'b1;
            w_load_val  = LD_GAP;
         end
         ST_GAP2:  if (w_zero) w_state_nxt = ST_DONE;
         ST_DONE: begin
            // Holding req across DONE chains straight into the next transaction.
            w_accept    = req;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (w_accept) begin
         w_state_nxt = ST_SETUP;
         w_load      = 1'b1;
         w_load_val  = LD_SETUP;
      end
   end

   // Outputs are decoded from the next state so every one is a flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b0;
         r_latch_d <= 1'b0;
         r_en_m    <= 1'b0;
         r_en_s    <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == ST_IDLE);
         r_en_m  <= (w_state_nxt == ST_MOPEN);
         r_en_s  <= (w_state_nxt == ST_SOPEN);
         r_ack   <= (w_state_nxt == ST_DONE);
         r_err   <= (w_state_nxt == ST_DONE) && (q_in != r_latch_d);
         if (w_accept) begin
            r_latch_d <= din;
         end
      end
   end

   assign ready   = r_ready;
   assign latch_d = r_latch_d;
   assign en_m    = r_en_m;
   assign en_s    = r_en_s;
   assign ack     = r_ack;
   assign err     = r_err;

endmodule
